// File: rtl/hazard_ctrl_unit.sv
// Load-use / jump / memory-busy hazard control between ID and EX.
// Drives front-end enables and flushes, and counts load-use stall cycles.
module hazard_ctrl_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_STALL = 1,
    parameter int PERF_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] ID_Rs,
    input  logic [REG_ADDR_W-1:0] ID_Rt,
    input  logic                  ID_UseRs,
    input  logic                  ID_UseRt,
    input  logic [REG_ADDR_W-1:0] EX_WR_out,
    input  logic                  EX_MemtoReg,
    input  logic [1:0]            EX_JumpOP,
    input  logic                  MEM_Busy,
    output logic                  PCWrite,
    output logic                  IF_IDWrite,
    output logic                  IF_Flush,
    output logic                  ID_Flush,
    output logic                  Stall_Active,
    output logic [PERF_W-1:0]     Stall_Cycles
);

    typedef enum logic {
        IDLE,
        LU_STALL
    } state_t;

    localparam bit       HZ_EN = (LOAD_STALL != 0);
    localparam bit       MULTI = (LOAD_STALL > 1);
    localparam logic [2:0] LS_M1 = 3'(LOAD_STALL - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_cnt;
    logic [2:0]          w_cnt_nxt;
    logic [PERF_W-1:0]   r_stall_cycles;
    logic                w_hz;
    logic                w_rs_hit;
    logic                w_rt_hit;
    logic                w_jump;
    logic                w_sat;

    assign w_rs_hit = ID_UseRs && (EX_WR_out == ID_Rs);
    assign w_rt_hit = ID_UseRt && (EX_WR_out == ID_Rt);
    assign w_hz     = HZ_EN && EX_MemtoReg && (EX_WR_out != '0)
                      && (w_rs_hit || w_rt_hit);
    assign w_jump   = (EX_JumpOP != 2'b00);
    assign w_sat    = (r_stall_cycles == {PERF_W{1'b1}});

    assign Stall_Cycles = r_stall_cycles;

    // State, down-counter and saturating stall-cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_cnt          <= 3'd0;
            r_stall_cycles <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (Stall_Active && !w_sat) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
        end
    end

    // Next-state logic and prioritised front-end controls.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        PCWrite      = 1'b1;
        IF_IDWrite   = 1'b1;
        IF_Flush     = 1'b0;
        ID_Flush     = 1'b0;
        Stall_Active = 1'b0;
        if (!rst) begin
            PCWrite    = 1'b0;
            IF_IDWrite = 1'b0;
            IF_Flush   = 1'b1;
            ID_Flush   = 1'b1;
        end else if (MEM_Busy) begin
            PCWrite    = 1'b0;
            IF_IDWrite = 1'b0;
        end else if (w_jump) begin
            IF_Flush    = 1'b1;
            ID_Flush    = 1'b1;
            w_state_nxt = IDLE;
            w_cnt_nxt   = 3'd0;
        end else if ((r_state == IDLE && w_hz) || r_state == LU_STALL) begin
            PCWrite      = 1'b0;
            IF_IDWrite   = 1'b0;
            ID_Flush     = 1'b1;
            Stall_Active = 1'b1;
            if (r_state == IDLE) begin
                if (MULTI) begin
                    w_state_nxt = LU_STALL;
                    w_cnt_nxt   = LS_M1;
                end
            end else if (r_cnt == 3'd1) begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 3'd0;
            end else begin
                w_cnt_nxt = r_cnt - 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit with three stall-depth instances.
// Stimulus pushes expected outputs; a negedge monitor pops and compares.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ID_Rs, ID_Rt, EX_WR_out;
    logic       ID_UseRs, ID_UseRt, EX_MemtoReg, MEM_Busy;
    logic [1:0] EX_JumpOP;

    logic pc1, ifid1, iff1, idf1, sa1;
    logic pc3, ifid3, iff3, idf3, sa3;
    logic pc4, ifid4, iff4, idf4, sa4;
    logic [3:0]  sc1;
    logic [15:0] sc3, sc4;

    // {PCWrite, IF_IDWrite, IF_Flush, ID_Flush, Stall_Active}
    localparam logic [4:0] E_IDLE  = 5'b11000;
    localparam logic [4:0] E_STALL = 5'b00011;
    localparam logic [4:0] E_BUSY  = 5'b00000;
    localparam logic [4:0] E_JMP   = 5'b11110;
    localparam logic [4:0] E_RST   = 5'b00110;

    typedef struct {
        int         sel;
        logic [4:0] o;
        int         cyc;
        string      name;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_STALL(1), .PERF_W(4)) u1 (
        .clk(clk), .rst(rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt), .EX_WR_out(EX_WR_out),
        .EX_MemtoReg(EX_MemtoReg), .EX_JumpOP(EX_JumpOP),
        .MEM_Busy(MEM_Busy), .PCWrite(pc1), .IF_IDWrite(ifid1),
        .IF_Flush(iff1), .ID_Flush(idf1), .Stall_Active(sa1),
        .Stall_Cycles(sc1));

    hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_STALL(3), .PERF_W(16)) u3 (
        .clk(clk), .rst(rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt), .EX_WR_out(EX_WR_out),
        .EX_MemtoReg(EX_MemtoReg), .EX_JumpOP(EX_JumpOP),
        .MEM_Busy(MEM_Busy), .PCWrite(pc3), .IF_IDWrite(ifid3),
        .IF_Flush(iff3), .ID_Flush(idf3), .Stall_Active(sa3),
        .Stall_Cycles(sc3));

    hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_STALL(4), .PERF_W(16)) u4 (
        .clk(clk), .rst(rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt), .EX_WR_out(EX_WR_out),
        .EX_MemtoReg(EX_MemtoReg), .EX_JumpOP(EX_JumpOP),
        .MEM_Busy(MEM_Busy), .PCWrite(pc4), .IF_IDWrite(ifid4),
        .IF_Flush(iff4), .ID_Flush(idf4), .Stall_Active(sa4),
        .Stall_Cycles(sc4));

    // Monitor: compare the selected instance against the queued expectation.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t       e;
            logic [4:0] a;
            int         c;
            e = q.pop_front();
            case (e.sel)
                1:       begin a = {pc1, ifid1, iff1, idf1, sa1}; c = int'(sc1); end
                3:       begin a = {pc3, ifid3, iff3, idf3, sa3}; c = int'(sc3); end
                default: begin a = {pc4, ifid4, iff4, idf4, sa4}; c = int'(sc4); end
            endcase
            n_tests++;
            if (a !== e.o || c != e.cyc) begin
                n_fail++;
                $display("FAIL %s (u%0d): ctl=%b cyc=%0d, want ctl=%b cyc=%0d",
                         e.name, e.sel, a, c, e.o, e.cyc);
            end
        end
    end

    task automatic step(input int sel, input string nm,
                        input logic [4:0] o, input int cyc);
        exp_t e;
        e.sel  = sel;
        e.o    = o;
        e.cyc  = cyc;
        e.name = nm;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        ID_Rs = 0; ID_Rt = 0; EX_WR_out = 0;
        ID_UseRs = 0; ID_UseRt = 0; EX_MemtoReg = 0;
        MEM_Busy = 0; EX_JumpOP = 2'b00;
    endtask

    task automatic do_reset(input int sel);
        rst = 1'b0;
        step(sel, "reset", E_RST, 0);
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        clr();
        rst = 1'b0;
        @(posedge clk);
        #1;

        // LOAD_STALL=1 instance
        do_reset(1);
        step(1, "idle_after_rst", E_IDLE, 0);
        EX_MemtoReg = 1; EX_WR_out = 8; ID_Rs = 8; ID_UseRs = 1;
        step(1, "ls1_rs_stall", E_STALL, 0);
        EX_MemtoReg = 0;
        step(1, "ls1_bubble", E_IDLE, 1);
        EX_MemtoReg = 1; EX_WR_out = 0; ID_Rs = 0; ID_UseRs = 1;
        step(1, "r0_no_stall", E_IDLE, 1);
        EX_WR_out = 8; ID_Rs = 8; ID_UseRs = 0;
        step(1, "use_rs_off", E_IDLE, 1);
        ID_Rs = 0; ID_Rt = 8; ID_UseRt = 0;
        step(1, "use_rt_off", E_IDLE, 1);
        ID_UseRt = 1;
        for (int k = 0; k < 18; k++) begin
            step(1, "sat_run", E_STALL, (k + 1 > 15) ? 15 : k + 1);
        end
        clr();
        step(1, "sat_hold", E_IDLE, 15);

        // LOAD_STALL=3 instance
        do_reset(3);
        EX_MemtoReg = 1; EX_WR_out = 8; ID_Rt = 8; ID_UseRt = 1;
        step(3, "ls3_det", E_STALL, 0);
        EX_MemtoReg = 0;
        step(3, "ls3_st2", E_STALL, 1);
        step(3, "ls3_st3", E_STALL, 2);
        step(3, "ls3_done", E_IDLE, 3);
        EX_MemtoReg = 1; EX_JumpOP = 2'b01;
        step(3, "jump_hz", E_JMP, 3);
        clr();
        step(3, "after_jump", E_IDLE, 3);
        EX_MemtoReg = 1; EX_WR_out = 8; ID_Rs = 8; ID_UseRs = 1;
        step(3, "abort_det", E_STALL, 3);
        EX_MemtoReg = 0; EX_JumpOP = 2'b10;
        step(3, "abort_jump", E_JMP, 4);
        clr();
        step(3, "abort_idle", E_IDLE, 4);
        EX_MemtoReg = 1; EX_WR_out = 8; ID_Rs = 8; ID_UseRs = 1;
        step(3, "mid_det", E_STALL, 4);
        EX_MemtoReg = 0;
        step(3, "mid_st2", E_STALL, 5);
        rst = 1'b0;
        step(3, "mid_rst", E_RST, 0);
        rst = 1'b1;
        step(3, "post_rst", E_IDLE, 0);

        // LOAD_STALL=4 instance
        clr();
        do_reset(4);
        EX_MemtoReg = 1; EX_WR_out = 8; ID_Rs = 8; ID_UseRs = 1;
        step(4, "ls4_det", E_STALL, 0);
        EX_MemtoReg = 0; MEM_Busy = 1;
        step(4, "busy1", E_BUSY, 1);
        step(4, "busy2", E_BUSY, 1);
        MEM_Busy = 0;
        step(4, "ls4_st2", E_STALL, 1);
        step(4, "ls4_st3", E_STALL, 2);
        step(4, "ls4_st4", E_STALL, 3);
        step(4, "ls4_done", E_IDLE, 4);
        MEM_Busy = 1; EX_JumpOP = 2'b01;
        step(4, "busy_jump", E_BUSY, 4);
        MEM_Busy = 0;
        step(4, "jump_after_busy", E_JMP, 4);
        clr();
        step(4, "final_idle", E_IDLE, 4);

        @(negedge clk);
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised successor to the pipeline hazard detection unit of the 5-stage MIPS core. It sits between ID and EX. It detects load-use hazards and stalls the front end for a configurable number of cycles using an internal counter and FSM. It also flushes IF/ID on a jump resolved in EX, freezes the front end while data memory is busy, and keeps a saturating count of stall cycles for performance measurement.

Parameters:
REG_ADDR_W, 5, register-address width
LOAD_STALL, 1, front-end stall cycles per load-use hazard (0..7; 0 disables load-use stalling)
PERF_W, 16, width of the stall-cycle performance counter

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous reset, active low
ID_Rs  input  REG_ADDR_W  rs of instruction in ID
ID_Rt  input  REG_ADDR_W  rt of instruction in ID
ID_UseRs  input  1  ID instruction reads rs
ID_UseRt  input  1  ID instruction reads rt
EX_WR_out  input  REG_ADDR_W  destination register of instruction in EX
EX_MemtoReg  input  1  EX instruction is a load
EX_JumpOP  input  2  nonzero = jump/taken branch resolved in EX
MEM_Busy  input  1  data memory not ready; whole pipeline must hold
PCWrite  output  1  PC update enable
IF_IDWrite  output  1  IF/ID register write enable
IF_Flush  output  1  clear IF/ID
ID_Flush  output  1  clear ID/EX (insert bubble)
Stall_Active  output  1  load-use stall in progress this cycle
Stall_Cycles  output  PERF_W  saturating count of load-use stall cycles

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, Stall_Cycles=0. While rst=0, outputs are PCWrite=0, IF_IDWrite=0, IF_Flush=1, ID_Flush=1, Stall_Active=0.
- Hazard term: hz = EX_MemtoReg & (EX_WR_out!=0) & ((ID_UseRs & EX_WR_out==ID_Rs) | (ID_UseRt & EX_WR_out==ID_Rt)). Register $0 never causes a stall. hz is forced to 0 when LOAD_STALL=0.
- States: IDLE, LU_STALL. The counter cnt is 3 bits wide.
- Output priority, highest first (all outputs are combinational from state and inputs):
  1. MEM_Busy=1: PCWrite=0, IF_IDWrite=0, IF_Flush=0, ID_Flush=0, Stall_Active=0. State, cnt and Stall_Cycles hold. A pending jump is deferred, because EX is frozen and EX_JumpOP stays stable.
  2. EX_JumpOP!=0: PCWrite=1, IF_IDWrite=1, IF_Flush=1, ID_Flush=1, Stall_Active=0. Next state is IDLE with cnt=0, aborting any LU_STALL.
  3. Stall condition (IDLE & hz) or state==LU_STALL: PCWrite=0, IF_IDWrite=0, IF_Flush=0, ID_Flush=1, Stall_Active=1.
  4. Otherwise: PCWrite=1, IF_IDWrite=1, IF_Flush=0, ID_Flush=0, Stall_Active=0.
- Transitions (only when not frozen by MEM_Busy and no jump):
  - IDLE & hz & LOAD_STALL>1: go to LU_STALL, load cnt=LOAD_STALL-1.
  - IDLE & hz & LOAD_STALL==1: remain in IDLE. The single stall cycle is the detection cycle.
  - LU_STALL: cnt decrements each cycle. When cnt==1, go to IDLE with cnt=0.
  - A new hz seen while in LU_STALL is ignored. EX holds a bubble then, so hz cannot re-trigger until the state returns to IDLE.
- Latency: total front-end stall per hazard is exactly LOAD_STALL cycles, with the detection cycle counted as the first.
- Stall_Cycles: increments on each rising edge where Stall_Active=1. It saturates at all-ones and never wraps.

Test Plan:
- LOAD_STALL=1, EX_MemtoReg=1, EX_WR_out=8, ID_Rs=8, ID_UseRs=1 -> one cycle with PCWrite=0, IF_IDWrite=0, ID_Flush=1; next cycle (EX bubble) all normal; Stall_Cycles=1.
- LOAD_STALL=3, same hazard on rt (ID_Rt=8, ID_UseRt=1) -> Stall_Active=1 for exactly 3 cycles, then IDLE; Stall_Cycles=3.
- EX_WR_out=0 matching ID_Rs=0, or ID_UseRs=0 with a match -> no stall, all enables 1.
- LOAD_STALL=4, hazard raised, MEM_Busy=1 on the second stall cycle for 2 cycles -> all flushes and enables 0 during busy, cnt frozen; stall resumes after busy and ends after 4 counted stall cycles total.
- EX_JumpOP=2'b01 together with hz=1 -> IF_Flush=1, ID_Flush=1, PCWrite=1, state IDLE, Stall_Cycles unchanged.
- rst driven low mid-LU_STALL -> outputs go immediately to the reset values, Stall_Cycles=0; after release with no hazard, all enables are 1. Separately, preload by running 2^PERF_W+2 stall cycles -> Stall_Cycles stays at all-ones.
